// File: rtl/fifo_rd_ctrl.sv
// Purpose: read-side controller of the async FIFO. It synchronises the write pointer,
//   keeps the read pointer, flags EMPTY and feeds a one-deep registered output stage.
// Latency: a new write becomes visible in wq2 two R_CLK edges after W_GRAY_PTR changes.
//   EMPTY falls on the 3rd edge and OUT_VALID rises on the 4th. After that it runs at 1 word/cycle.
// Backpressure: when OUT_VALID is high and OUT_READY is low, the stage and the read pointer hold.
//   No combinational path exists from OUT_READY to OUT_VALID or OUT_DATA.
//
// Ports:
//   R_CLK       read-domain clock
//   R_RST       asynchronous active-low reset
//   W_GRAY_PTR  Gray write pointer from the write domain (asynchronous to R_CLK)
//   RD_DATA     combinational memory output at RD_ADDR
//   RD_ADDR     memory read address (low bits of the binary read pointer)
//   R_GRAY_PTR  registered Gray read pointer, to the write-domain synchroniser
//   EMPTY       registered empty flag
//   OUT_DATA    output-stage word
//   OUT_VALID   OUT_DATA holds an unconsumed word
//   OUT_READY   consumer takes OUT_DATA this cycle
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                     R_CLK,
  input  logic                     R_RST,
  input  logic [ADDRESS_WIDTH:0]   W_GRAY_PTR,
  input  logic [DATA_WIDTH-1:0]    RD_DATA,
  output logic [ADDRESS_WIDTH-1:0] RD_ADDR,
  output logic [ADDRESS_WIDTH:0]   R_GRAY_PTR,
  output logic                     EMPTY,
  output logic [DATA_WIDTH-1:0]    OUT_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY
);

  localparam int PW = ADDRESS_WIDTH + 1;

  logic [PW-1:0] wq1;
  logic [PW-1:0] wq2;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] next_bin;
  logic [PW-1:0] next_gray;
  logic          pop;

  // Two-flop synchroniser for the write pointer. Only wq2 is used, because wq1 may be metastable.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= W_GRAY_PTR;
      wq2 <= wq1;
    end
  end

  // Pop when there is data and the output stage is free or is draining this cycle.
  // Inputs here are EMPTY, OUT_VALID and OUT_READY. EMPTY and OUT_VALID are flops.
  // OUT_READY only steers the flop enables, so it reaches no output combinationally.
  always_comb begin
    pop       = !EMPTY && (!OUT_VALID || OUT_READY);
    next_bin  = rd_bin + {{(PW-1){1'b0}}, pop};
    next_gray = next_bin ^ (next_bin >> 1);
  end

  // EMPTY is compared against the post-pop pointer.
  // The pop that drains the last entry therefore raises EMPTY on the same edge, and no underflow pop can follow.
  // The full-width compare includes the wrap bit.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      rd_bin     <= '0;
      R_GRAY_PTR <= '0;
      EMPTY      <= 1'b1;
    end else begin
      rd_bin     <= next_bin;
      R_GRAY_PTR <= next_gray;
      EMPTY      <= (next_gray == wq2);
    end
  end

  // One-deep output register. A pop overwrites it; otherwise an accepted word clears valid.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
    end else if (pop) begin
      OUT_DATA  <= RD_DATA;
      OUT_VALID <= 1'b1;
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

  assign RD_ADDR = rd_bin[ADDRESS_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Testbench for fifo_rd_ctrl.
// A count-based reference model tracks words written, words popped and the output stage.
// A two-entry delay line models pointer synchronisation. Directed checks pin down the edge-exact latencies.
module tb_fifo_rd_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << PW;
  localparam int VW    = 2 + AW + PW + DW;

  logic          R_CLK;
  logic          R_RST = 1'b1;
  logic [PW-1:0] W_GRAY_PTR = '0;
  logic [DW-1:0] RD_DATA;
  logic [AW-1:0] RD_ADDR;
  logic [PW-1:0] R_GRAY_PTR;
  logic          EMPTY;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;

  logic [DW-1:0] mem [DEPTH];
  assign RD_DATA = mem[RD_ADDR];

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .R_CLK      (R_CLK),
    .R_RST      (R_RST),
    .W_GRAY_PTR (W_GRAY_PTR),
    .RD_DATA    (RD_DATA),
    .RD_ADDR    (RD_ADDR),
    .R_GRAY_PTR (R_GRAY_PTR),
    .EMPTY      (EMPTY),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY)
  );

  initial R_CLK = 1'b0;
  always #5 R_CLK = ~R_CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;

  // Reference model state. Counts are plain integers; the model never reads DUT outputs.
  int            m_sync0, m_sync1;
  int            m_rd, m_pops;
  bit            m_empty, m_ov;
  logic [DW-1:0] m_od;

  wire [VW-1:0] dut_vec = {EMPTY, OUT_VALID, RD_ADDR, R_GRAY_PTR, OUT_DATA};

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b % PMOD);
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(input logic [PW-1:0] g);
    int b;
    b = 0;
    for (int i = PW - 1; i >= 0; i--) b = (b << 1) | ((b & 1) ^ int'(g[i]));
    return b;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_empty, m_ov, AW'(m_rd % DEPTH), to_gray(m_rd), m_od};
  endfunction

  task automatic model_reset();
    m_sync0 = 0; m_sync1 = 0; m_rd = 0; m_pops = 0;
    m_empty = 1'b1; m_ov = 1'b0; m_od = '0;
  endtask

  // One read-clock edge of the model. Inputs are still the values the DUT saw at this edge.
  task automatic model_step();
    bit p;
    p = !m_empty && (!m_ov || OUT_READY);
    if (p) begin
      m_od   = mem[m_rd % DEPTH];
      m_ov   = 1'b1;
      m_rd   = (m_rd + 1) % PMOD;
      m_pops = m_pops + 1;
    end else if (m_ov && OUT_READY) begin
      m_ov = 1'b0;
    end
    m_empty = (m_rd == m_sync1);
    m_sync1 = m_sync0;
    m_sync0 = from_gray(W_GRAY_PTR);
  endtask

  task automatic tick();
    @(posedge R_CLK);
    if (R_RST) model_step();
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_cnt % DEPTH] = d;
    wr_cnt = wr_cnt + 1;
    W_GRAY_PTR = to_gray(wr_cnt);
  endtask

  task automatic do_reset();
    R_RST = 1'b0;
    W_GRAY_PTR = '0;
    OUT_READY = 1'b0;
    wr_cnt = 0;
    model_reset();
    #1;
    @(negedge R_CLK);
    R_RST = 1'b1;
  endtask

  task automatic test_reset();
    R_RST = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== {1'b1, 1'b0, {AW{1'b0}}, {PW{1'b0}}, {DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", dut_vec, {1'b1, 1'b0, {AW{1'b0}}, {PW{1'b0}}, {DW{1'b0}}});
    end
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if ({EMPTY, OUT_VALID, RD_ADDR, R_GRAY_PTR} !== {1'b1, 1'b0, 3'd0, 4'b0000}) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d: got %b%b %0d %b expected 10 0 0000", k, EMPTY, OUT_VALID, RD_ADDR, R_GRAY_PTR);
      end
    end
  endtask

  task automatic test_single();
    bit exp_empty [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bit exp_valid [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    OUT_READY = 1'b1;
    push_word(8'hA5);
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (EMPTY !== exp_empty[k-1] || OUT_VALID !== exp_valid[k-1]) begin
        n_fail++;
        $display("FAIL single_edge%0d: got empty=%b valid=%b expected empty=%b valid=%b",
                 k, EMPTY, OUT_VALID, exp_empty[k-1], exp_valid[k-1]);
      end
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL single_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
      end
      if (k == 4) begin
        n_checks++;
        if (OUT_DATA !== 8'hA5 || R_GRAY_PTR !== 4'b0001) begin
          n_fail++;
          $display("FAIL single_data: got data=%h gray=%b expected a5 0001", OUT_DATA, R_GRAY_PTR);
        end
      end
    end
  endtask

  task automatic test_burst();
    do_reset();
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
    for (int k = 1; k <= 13; k++) begin
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL burst_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
      end
      if (k >= 4 && k <= 11) begin
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'(8'h10 + k - 4)) begin
          n_fail++;
          $display("FAIL burst_word k=%0d: got valid=%b data=%h expected 1 %h", k, OUT_VALID, OUT_DATA, 8'(8'h10 + k - 4));
        end
      end
      if (k == 11) begin
        n_checks++;
        if ({EMPTY, RD_ADDR, R_GRAY_PTR} !== {1'b1, 3'd0, 4'b1100}) begin
          n_fail++;
          $display("FAIL burst_end: got empty=%b addr=%0d gray=%b expected 1 0 1100", EMPTY, RD_ADDR, R_GRAY_PTR);
        end
      end
      if (k == 12) begin
        n_checks++;
        if (OUT_VALID !== 1'b0) begin
          n_fail++;
          $display("FAIL burst_drain: got valid=%b expected 0", OUT_VALID);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_word(8'h01); push_word(8'h02); push_word(8'h03);
    for (int k = 1; k <= 12; k++) begin
      if (k == 10) OUT_READY = 1'b1;
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL bp_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
      end
      if (k >= 4 && k <= 9) begin
        n_checks++;
        if ({OUT_VALID, OUT_DATA, R_GRAY_PTR, EMPTY} !== {1'b1, 8'h01, 4'b0001, 1'b0}) begin
          n_fail++;
          $display("FAIL bp_hold k=%0d: got valid=%b data=%h gray=%b empty=%b expected 1 01 0001 0",
                   k, OUT_VALID, OUT_DATA, R_GRAY_PTR, EMPTY);
        end
      end
      if (k == 10 || k == 11) begin
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'(k - 8)) begin
          n_fail++;
          $display("FAIL bp_release k=%0d: got valid=%b data=%h expected 1 %h", k, OUT_VALID, OUT_DATA, 8'(k - 8));
        end
      end
      if (k == 12) begin
        n_checks++;
        if ({OUT_VALID, EMPTY, R_GRAY_PTR} !== {1'b0, 1'b1, 4'b0010}) begin
          n_fail++;
          $display("FAIL bp_end: got valid=%b empty=%b gray=%b expected 0 1 0010", OUT_VALID, EMPTY, R_GRAY_PTR);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int xfers;
    xfers = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (wr_cnt < 16 && (wr_cnt - m_pops) < DEPTH && $urandom_range(0, 1) == 1)
        push_word(8'($urandom));
      OUT_READY = ($urandom_range(0, 3) != 0);
      if (OUT_VALID && OUT_READY) xfers++;
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL wrap_model c=%0d: got %h expected %h", c, dut_vec, model_vec());
      end
      if (m_pops == 16 && !m_ov) break;
    end
    n_checks++;
    if ({EMPTY, OUT_VALID, RD_ADDR, R_GRAY_PTR} !== {1'b1, 1'b0, 3'd0, 4'b0000} || xfers !== 16) begin
      n_fail++;
      $display("FAIL wrap_end: got empty=%b valid=%b addr=%0d gray=%b xfers=%0d expected 1 0 0 0000 16",
               EMPTY, OUT_VALID, RD_ADDR, R_GRAY_PTR, xfers);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--)
        if ((wr_cnt - m_pops) < DEPTH) push_word(8'($urandom));
      OUT_READY = ($urandom_range(0, 2) != 0);
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random_model c=%0d: got %h expected %h", c, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) push_word(8'(8'h60 + i));
    for (int k = 1; k <= 5; k++) tick();
    #2;
    R_RST = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== {1'b1, 1'b0, {AW{1'b0}}, {PW{1'b0}}, {DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL midreset_clear: got %h expected %h", dut_vec, {1'b1, 1'b0, {AW{1'b0}}, {PW{1'b0}}, {DW{1'b0}}});
    end
    @(negedge R_CLK);
    R_RST = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL midreset_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
      end
      if (k <= 3) begin
        n_checks++;
        if (EMPTY !== (k < 3)) begin
          n_fail++;
          $display("FAIL midreset_resync k=%0d: got empty=%b expected %b", k, EMPTY, (k < 3));
        end
      end
      if (k == 4) begin
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h60) begin
          n_fail++;
          $display("FAIL midreset_first: got valid=%b data=%h expected 1 60", OUT_VALID, OUT_DATA);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    model_reset();
    #2;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
